// File: rtl/hash_lookup.sv
// Open-addressed hash table lookup engine: linear probing over an internal
// key/value table, up to MAX_PROBE entries per lookup, one response strobe.
module hash_lookup #(
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned KEY_W     = 96,
  parameter int unsigned VAL_W     = 32,
  parameter int unsigned MAX_PROBE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic [31:0]      req_hash,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [VAL_W-1:0] resp_value,
  output logic [2:0]       resp_probes,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [VAL_W-1:0] wr_value
);

  localparam int unsigned DEPTH       = 1 << IDX_W;
  localparam logic [2:0]  MAX_PROBE_C = 3'(MAX_PROBE);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_READ    = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_probe;
  logic [KEY_W-1:0] r_key;

  logic             r_req_ready;
  logic             r_resp_valid;
  logic             r_resp_hit;
  logic [VAL_W-1:0] r_resp_value;
  logic [2:0]       r_resp_probes;

  logic [DEPTH-1:0] r_valid;
  logic [KEY_W-1:0] r_key_mem [DEPTH];
  logic [VAL_W-1:0] r_val_mem [DEPTH];
  logic             r_rd_valid;
  logic [KEY_W-1:0] r_rd_key;
  logic [VAL_W-1:0] r_rd_value;

  logic w_accept;
  logic w_hit;
  logic w_miss;
  logic w_advance;
  logic w_key_match;

  // Only the low IDX_W hash bits select the home bucket.
  if (IDX_W < 32) begin : g_hash_unused
    logic w_unused_hash;
    assign w_unused_hash = ^req_hash[31:IDX_W];
  end

  assign w_key_match = (r_rd_key == r_key);

  // Next-state and per-cycle decision decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        w_state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (r_rd_valid && w_key_match) begin
          w_hit       = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (!r_rd_valid || (r_probe >= MAX_PROBE_C)) begin
          w_miss      = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, probe cursor and registered response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_probe       <= 3'd0;
      r_key         <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_resp_value  <= '0;
      r_resp_probes <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_RESP);
      if (w_accept) begin
        r_key   <= req_key;
        r_idx   <= req_hash[IDX_W-1:0];
        r_probe <= 3'd1;
      end
      if (w_advance) begin
        r_idx   <= r_idx + IDX_W'(1);
        r_probe <= r_probe + 3'd1;
      end
      if (w_hit || w_miss) begin
        r_resp_hit    <= w_hit;
        r_resp_value  <= w_hit ? r_rd_value : '0;
        r_resp_probes <= r_probe;
      end
    end
  end

  // Valid flags live in flops so reset can clear them in one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        r_valid[wr_idx] <= wr_valid;
      end
      if (r_state == ST_READ) begin
        r_rd_valid <= r_valid[r_idx];
      end
    end
  end

  // Key/value storage: synchronous read, reads see pre-write contents.
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) begin
      r_key_mem[wr_idx] <= wr_key;
      r_val_mem[wr_idx] <= wr_value;
    end
    if (r_state == ST_READ) begin
      r_rd_key   <= r_key_mem[r_idx];
      r_rd_value <= r_val_mem[r_idx];
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_hit    = r_resp_hit;
  assign resp_value  = r_resp_value;
  assign resp_probes = r_resp_probes;

endmodule

// File: tb/tb_hash_lookup.sv
// Directed bench for hash_lookup: table-driven lookups after a preload,
// plus hand sequences for exhaustion, delete, reset abort and write collision.
module tb_hash_lookup;

  localparam int unsigned IDX_W = 8;
  localparam int unsigned KEY_W = 96;
  localparam int unsigned VAL_W = 32;

  localparam logic [95:0] K_ABC = "abcdefghijkl";
  localparam logic [95:0] K_A   = 96'h0000_0000_0000_0000_0000_00A1;
  localparam logic [95:0] K_B   = 96'h0000_0000_0000_0000_0000_00B2;
  localparam logic [95:0] K_T   = 96'h1234_5678_9ABC_DEF0_0000_0077;
  localparam logic [95:0] K_X   = 96'hFFFF_0000_FFFF_0000_FFFF_0055;
  localparam logic [95:0] K0    = 96'h0000_0001_0000_0000_0000_0000;
  localparam logic [95:0] K1    = 96'h0000_0002_0000_0000_0000_0000;
  localparam logic [95:0] K2    = 96'h0000_0003_0000_0000_0000_0000;
  localparam logic [95:0] K3    = 96'h0000_0004_0000_0000_0000_0000;

  logic             CLK = 1'b0;
  logic             RST;
  logic             req_valid;
  logic             req_ready;
  logic [KEY_W-1:0] req_key;
  logic [31:0]      req_hash;
  logic             resp_valid;
  logic             resp_hit;
  logic [VAL_W-1:0] resp_value;
  logic [2:0]       resp_probes;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_valid;
  logic [KEY_W-1:0] wr_key;
  logic [VAL_W-1:0] wr_value;

  always #5 CLK = ~CLK;

  hash_lookup #(
    .IDX_W(IDX_W), .KEY_W(KEY_W), .VAL_W(VAL_W), .MAX_PROBE(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_hash(req_hash),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_value(resp_value), .resp_probes(resp_probes),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
    .wr_key(wr_key), .wr_value(wr_value)
  );

  typedef struct {
    logic [95:0] key;
    logic [31:0] hash;
    logic        hit;
    logic [31:0] value;
    logic [2:0]  probes;
  } vec_t;

  vec_t vecs [11];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] idx, input logic v, input logic [95:0] k, input logic [31:0] val);
    @(negedge CLK);
    wr_en = 1'b1; wr_idx = idx; wr_valid = v; wr_key = k; wr_value = val;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  // One lookup: optional ignored request pulses, optional same-cycle write to 0x10.
  task automatic lookup(input logic [95:0] k, input logic [31:0] h, input bit pulse,
                        input bit coll, input string tag, input logic [2:0] exp_pr,
                        output logic hit, output logic [31:0] val,
                        output logic [2:0] pr, output int lat);
    @(negedge CLK);
    chk($sformatf("%s_ready", tag), 128'(req_ready), 128'd1);
    req_valid = 1'b1; req_key = k; req_hash = h;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    if (coll) begin
      wr_en = 1'b1; wr_idx = 8'h10; wr_valid = 1'b1; wr_key = K_ABC; wr_value = 32'hBEEF0001;
    end
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      if (pulse && lat < 6 && (lat % 2) == 0) begin
        req_valid = 1'b1; req_hash = 32'h24;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
      if (coll && lat == 1) wr_en = 1'b0;
      if (resp_valid) break;
    end
    req_valid = 1'b0;
    hit = resp_hit; val = resp_value; pr = resp_probes;
    if (!resp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no resp_valid after %0d cycles, want one", tag, lat);
    end
    @(posedge CLK); #1;
    chk($sformatf("%s_strobe_len", tag), 128'(resp_valid), 128'd0);
    chk($sformatf("%s_probes_hold", tag), 128'(resp_probes), 128'(exp_pr));
  endtask

  logic        hit;
  logic [31:0] val;
  logic [2:0]  pr;
  int          lat;
  int          n_resp;

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_key = '0; req_hash = '0;
    wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0; wr_key = '0; wr_value = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst_ready", 128'(req_ready), 128'd1);
    chk("rst_valid", 128'(resp_valid), 128'd0);
    chk("rst_hit", 128'(resp_hit), 128'd0);
    chk("rst_value", 128'(resp_value), 128'd0);
    chk("rst_probes", 128'(resp_probes), 128'd0);

    // Empty table miss.
    lookup(K_ABC, 32'h10, 1'b0, 1'b0, "empty", 3'd1, hit, val, pr, lat);
    chk("empty_hit", 128'(hit), 128'd0);
    chk("empty_value", 128'(val), 128'd0);
    chk("empty_probes", 128'(pr), 128'd1);
    chk("empty_lat", 128'(lat), 128'd2);

    wr(8'h10, 1'b1, K_ABC, 32'hCAFEF00D);
    wr(8'hFE, 1'b1, K_A, 32'h21);
    wr(8'hFF, 1'b1, K_B, 32'h22);
    wr(8'h00, 1'b1, K_T, 32'h11);
    wr(8'h20, 1'b1, K0, 32'h100);
    wr(8'h21, 1'b1, K1, 32'h101);
    wr(8'h22, 1'b1, K2, 32'h102);
    wr(8'h23, 1'b1, K3, 32'h103);
    wr(8'h24, 1'b1, K_X, 32'h55);

    vecs[0]  = '{K_ABC, 32'h12345610, 1'b1, 32'hCAFEF00D, 3'd1};
    vecs[1]  = '{K_T, 32'h000000FE, 1'b1, 32'h11, 3'd3};
    vecs[2]  = '{K_X, 32'h24, 1'b1, 32'h55, 3'd1};
    vecs[3]  = '{K_X, 32'h23, 1'b1, 32'h55, 3'd2};
    vecs[4]  = '{K_ABC ^ 96'h1, 32'h10, 1'b0, 32'h0, 3'd2};
    vecs[5]  = '{K_ABC ^ {1'b1, 95'b0}, 32'h10, 1'b0, 32'h0, 3'd2};
    vecs[6]  = '{K_B, 32'hFF, 1'b1, 32'h22, 3'd1};
    vecs[7]  = '{K_T, 32'h00AB00FF, 1'b1, 32'h11, 3'd2};
    vecs[8]  = '{K1, 32'hABCD0020, 1'b1, 32'h101, 3'd2};
    vecs[9]  = '{K3, 32'h21, 1'b1, 32'h103, 3'd3};
    vecs[10] = '{K_X, 32'h21, 1'b1, 32'h55, 3'd4};

    for (int i = 0; i < 11; i++) begin
      lookup(vecs[i].key, vecs[i].hash, 1'b0, 1'b0, $sformatf("v%0d", i),
             vecs[i].probes, hit, val, pr, lat);
      chk($sformatf("v%0d_hit", i), 128'(hit), 128'(vecs[i].hit));
      chk($sformatf("v%0d_value", i), 128'(val), 128'(vecs[i].value));
      chk($sformatf("v%0d_probes", i), 128'(pr), 128'(vecs[i].probes));
      chk($sformatf("v%0d_lat", i), 128'(lat), 128'(2 * int'(vecs[i].probes)));
    end

    // Probe exhaustion with request pulses that must be ignored.
    lookup(K_X, 32'h20, 1'b1, 1'b0, "exhaust", 3'd4, hit, val, pr, lat);
    chk("exhaust_hit", 128'(hit), 128'd0);
    chk("exhaust_value", 128'(val), 128'd0);
    chk("exhaust_probes", 128'(pr), 128'd4);
    chk("exhaust_lat", 128'(lat), 128'd8);
    n_resp = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (resp_valid) n_resp++;
    end
    chk("exhaust_no_extra_resp", 128'(n_resp), 128'd0);

    // Delete the entry at 0x24.
    wr(8'h24, 1'b0, K_X, 32'h55);
    lookup(K_X, 32'h24, 1'b0, 1'b0, "deleted", 3'd1, hit, val, pr, lat);
    chk("deleted_hit", 128'(hit), 128'd0);
    chk("deleted_value", 128'(val), 128'd0);
    chk("deleted_probes", 128'(pr), 128'd1);

    // Reset during COMPARE of probe 2; a write during reset must be dropped.
    @(negedge CLK);
    req_valid = 1'b1; req_key = K1; req_hash = 32'h20;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    wr_en = 1'b1; wr_idx = 8'h10; wr_valid = 1'b1; wr_key = K_ABC; wr_value = 32'h77;
    @(posedge CLK); #1;
    RST = 1'b0; wr_en = 1'b0;
    chk("abort_ready", 128'(req_ready), 128'd1);
    n_resp = 0;
    repeat (12) begin
      if (resp_valid) n_resp++;
      @(posedge CLK); #1;
    end
    chk("abort_no_resp", 128'(n_resp), 128'd0);
    lookup(K_ABC, 32'h12345610, 1'b0, 1'b0, "post_rst", 3'd1, hit, val, pr, lat);
    chk("post_rst_hit", 128'(hit), 128'd0);
    chk("post_rst_probes", 128'(pr), 128'd1);
    chk("post_rst_lat", 128'(lat), 128'd2);

    // Write to 0x10 in the READ cycle: old value now, new value next time.
    wr(8'h10, 1'b1, K_ABC, 32'hCAFEF00D);
    lookup(K_ABC, 32'h10, 1'b0, 1'b1, "coll", 3'd1, hit, val, pr, lat);
    chk("coll_hit", 128'(hit), 128'd1);
    chk("coll_old_value", 128'(val), 128'hCAFEF00D);
    lookup(K_ABC, 32'h10, 1'b0, 1'b0, "coll2", 3'd1, hit, val, pr, lat);
    chk("coll2_hit", 128'(hit), 128'd1);
    chk("coll2_new_value", 128'(val), 128'hBEEF0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
